// File: rtl/display_gen_pkg.sv
// Shared types and constants for the display counter generator.
// Key indices map the push-keys onto their roles.
package display_gen_pkg;

    typedef enum logic {ST_RUN = 1'b0, ST_PAUSE = 1'b1} gen_state_t;

    localparam int KEY_RST  = 0;
    localparam int KEY_RUN  = 1;
    localparam int KEY_DIR  = 2;
    localparam int KEY_STEP = 3;
    localparam int NUM_KEYS = 4;

    function automatic logic [3:0] digit_max(input int decimal);
        return (decimal != 0) ? 4'd9 : 4'd15;
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Per-key three-flop synchronizer: z1 -> z2 gives the clean level, z3 gives
// the previous level for rising-edge detection.
module key_sync_edge #(
    parameter int N_KEYS = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [N_KEYS-1:0] raw,
    output logic [N_KEYS-1:0] level,
    output logic [N_KEYS-1:0] rise
);

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            logic [2:0] z_reg;

            always_ff @(posedge clk) begin
                if (srst) begin
                    z_reg <= '0;
                end else begin
                    z_reg <= {z_reg[1:0], raw[gi]};
                end
            end

            assign level[gi] = z_reg[1];
            assign rise[gi]  = z_reg[1] & ~z_reg[2];
        end
    endgenerate

endmodule

// File: rtl/display_counter_gen.sv
// N-digit hex/BCD up/down counter advanced by a prescaler tick, with
// run/pause, direction and single-step keys, driving display and LEDs.
module display_counter_gen
    import display_gen_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int DECIMAL       = 0,
    parameter int TICK_DIV      = 50_000_000,
    parameter int SIM_TICK_DIV  = 16,
    parameter int is_simulation = 0
) (
    input  logic                  clk,
    input  logic                  reset_p,
    input  logic [3:0]            key_sw_p,
    output logic [4*N_DIGITS-1:0] display_number,
    output logic [3:0]            led_p
);

    localparam int              DIV      = (is_simulation != 0) ? SIM_TICK_DIV : TICK_DIV;
    localparam int              PW       = $clog2(DIV);
    localparam logic [PW-1:0]   PRE_LAST = PW'(DIV - 1);
    localparam logic [3:0]      DMAX     = digit_max(DECIMAL);

    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_rise;
    logic                rst_key_reg;
    logic                rst_i;
    gen_state_t          state_reg, state_next;
    logic [PW-1:0]       pre_reg, pre_next;
    logic                tick;
    logic                count_ev;
    logic                down;
    logic [N_DIGITS-1:0][3:0] digit_reg;
    logic [N_DIGITS-1:0][3:0] digit_next;
    logic [N_DIGITS-1:0] at_limit;
    logic [N_DIGITS:0]   carry;
    logic                wrap_reg;
    logic                hb_reg;
    logic                dir_reg;
    logic                unused_keys;

    key_sync_edge #(.N_KEYS(NUM_KEYS)) u_keys (
        .clk   (clk),
        .srst  (reset_p),
        .raw   (key_sw_p),
        .level (key_level),
        .rise  (key_rise)
    );

    assign unused_keys = ^{key_rise[KEY_RST], key_rise[KEY_DIR],
                           key_level[KEY_RUN], key_level[KEY_STEP]};

    // Soft reset is one flop behind z2 so the synchronizer itself never resets it.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            rst_key_reg <= 1'b0;
        end else begin
            rst_key_reg <= key_level[KEY_RST];
        end
    end

    assign rst_i = reset_p | rst_key_reg;
    assign down  = key_level[KEY_DIR];
    assign tick  = (state_reg == ST_RUN) && (pre_reg == PRE_LAST);

    always_comb begin
        state_next = state_reg;
        pre_next   = '0;
        count_ev   = 1'b0;
        case (state_reg)
            ST_RUN: begin
                count_ev = tick;
                pre_next = tick ? '0 : pre_reg + 1'b1;
                if (key_rise[KEY_RUN]) begin
                    state_next = ST_PAUSE;
                    pre_next   = '0;
                end
            end
            default: begin
                // A run toggle wins over a simultaneous step.
                count_ev = key_rise[KEY_STEP] & ~key_rise[KEY_RUN];
                if (key_rise[KEY_RUN]) begin
                    state_next = ST_RUN;
                end
            end
        endcase
    end

    always_comb begin
        carry    = '0;
        carry[0] = count_ev;
        for (int i = 0; i < N_DIGITS; i++) begin
            carry[i+1] = carry[i] & at_limit[i];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign at_limit[gi] = down ? (digit_reg[gi] == 4'd0) : (digit_reg[gi] == DMAX);
            assign digit_next[gi] = !carry[gi]   ? digit_reg[gi] :
                                    at_limit[gi] ? (down ? DMAX : 4'd0) :
                                    down         ? digit_reg[gi] - 4'd1 :
                                                   digit_reg[gi] + 4'd1;
            assign display_number[gi*4 +: 4] = digit_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_reg <= ST_RUN;
            pre_reg   <= '0;
            digit_reg <= '0;
            wrap_reg  <= 1'b0;
            hb_reg    <= 1'b0;
            dir_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pre_reg   <= pre_next;
            dir_reg   <= down;
            if (count_ev) begin
                digit_reg <= digit_next;
                hb_reg    <= ~hb_reg;
            end
            if (carry[N_DIGITS]) begin
                wrap_reg <= 1'b1;
            end
        end
    end

    assign led_p = {hb_reg, wrap_reg, dir_reg, state_reg == ST_RUN};

endmodule

// File: tb/tb_display_counter_gen.sv
// Bench for display_counter_gen: a hex and a BCD instance share the keys and
// are compared every cycle against an integer-arithmetic reference model.
module tb_display_counter_gen;

    localparam int DIV_H = 16;
    localparam int DIV_B = 4;

    logic        clk = 1'b0;
    logic        reset_p;
    logic [3:0]  key_sw_p;
    logic [15:0] num_h, num_b;
    logic [3:0]  led_h, led_b;

    display_counter_gen #(
        .N_DIGITS(4), .DECIMAL(0), .TICK_DIV(50), .SIM_TICK_DIV(DIV_H), .is_simulation(1)
    ) dut_hex (
        .clk(clk), .reset_p(reset_p), .key_sw_p(key_sw_p),
        .display_number(num_h), .led_p(led_h)
    );

    display_counter_gen #(
        .N_DIGITS(4), .DECIMAL(1), .TICK_DIV(50), .SIM_TICK_DIV(DIV_B), .is_simulation(1)
    ) dut_bcd (
        .clk(clk), .reset_p(reset_p), .key_sw_p(key_sw_p),
        .display_number(num_b), .led_p(led_b)
    );

    always #5 clk = ~clk;

    // Reference model state: index 0 = hex instance, 1 = BCD instance.
    int m_div [2] = '{DIV_H, DIV_B};
    int m_mod [2] = '{65536, 10000};
    int m_val [2];
    int m_phase [2];
    bit m_run [2];
    bit m_wrap [2];
    bit m_hb [2];
    bit m_dir [2];
    bit [3:0] s1 = '0, s2 = '0, s3 = '0;
    bit s_rk = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_led(input int i);
        return {m_hb[i], m_wrap[i], m_dir[i], m_run[i]};
    endfunction

    // Advance the model by one rising edge using the inputs present at that edge.
    task automatic model_edge();
        bit       rst_i;
        bit [3:0] rise;
        bit       ev;
        rst_i = reset_p || s_rk;
        rise  = s2 & ~s3;
        for (int i = 0; i < 2; i++) begin
            if (rst_i) begin
                m_val[i] = 0; m_phase[i] = 0; m_run[i] = 1'b1;
                m_wrap[i] = 1'b0; m_hb[i] = 1'b0; m_dir[i] = 1'b0;
            end else begin
                if (m_run[i]) begin
                    ev = (m_phase[i] == m_div[i] - 1);
                    m_phase[i] = ev ? 0 : m_phase[i] + 1;
                    if (rise[1]) begin
                        m_run[i] = 1'b0;
                        m_phase[i] = 0;
                    end
                end else begin
                    ev = rise[3] && !rise[1];
                    if (rise[1]) m_run[i] = 1'b1;
                end
                if (ev) begin
                    if (!s2[2]) begin
                        if (m_val[i] == m_mod[i] - 1) begin m_val[i] = 0; m_wrap[i] = 1'b1; end
                        else m_val[i] = m_val[i] + 1;
                    end else begin
                        if (m_val[i] == 0) begin m_val[i] = m_mod[i] - 1; m_wrap[i] = 1'b1; end
                        else m_val[i] = m_val[i] - 1;
                    end
                    m_hb[i] = !m_hb[i];
                end
                m_dir[i] = s2[2];
            end
        end
        s_rk = reset_p ? 1'b0 : s2[0];
        if (reset_p) begin
            s1 = '0; s2 = '0; s3 = '0;
        end else begin
            s3 = s2; s2 = s1; s1 = key_sw_p;
        end
    endtask

    task automatic compare_all();
        bit digit_bad;
        digit_bad = 1'b0;
        check_eq("hex_num", 32'(num_h), 32'(m_val[0]));
        check_eq("hex_led", 32'(led_h), 32'(exp_led(0)));
        check_eq("bcd_num", 32'(num_b), 32'(to_bcd(m_val[1])));
        check_eq("bcd_led", 32'(led_b), 32'(exp_led(1)));
        for (int d = 0; d < 4; d++) begin
            if (num_b[d*4 +: 4] > 4'd9) digit_bad = 1'b1;
        end
        check_eq("bcd_digit_range", 32'(digit_bad), 32'(0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_reset();
        reset_p = 1'b1;
        run(2);
        reset_p = 1'b0;
    endtask

    task automatic pulse_key(input int idx);
        key_sw_p[idx] = 1'b1;
        step();
        key_sw_p[idx] = 1'b0;
    endtask

    initial begin
        int  frozen;
        int  v;
        bit  found;

        reset_p  = 1'b1;
        key_sw_p = '0;
        run(3);
        check_eq("reset_num", 32'(num_h), 32'h0);
        check_eq("reset_led", 32'(led_h), 32'h1);
        $display("reset: num=%h led=%b", num_h, led_h);

        // Hex count: 256 cycles at DIV 16 gives 16 increments.
        reset_p = 1'b0;
        run(256);
        check_eq("hex_count", 32'(num_h), 32'h0010);
        check_eq("hex_heartbeat", 32'(led_h[3]), 32'h0);
        check_eq("bcd_count", 32'(num_b), 32'h0064);
        $display("hex_count: hex=%h bcd=%h led=%b", num_h, num_b, led_h);

        // Wrap down from zero.
        reset_p = 1'b1;
        key_sw_p[2] = 1'b1;
        step();
        reset_p = 1'b0;
        run(16);
        check_eq("wrap_down_num", 32'(num_h), 32'hFFFF);
        check_eq("wrap_down_flag", 32'(led_h[2]), 32'h1);
        key_sw_p[2] = 1'b0;
        run(40);
        check_eq("wrap_sticky", 32'(led_h[2]), 32'h1);
        $display("wrap_down: hex=%h led=%b", num_h, led_h);

        // BCD carry across three digits.
        do_reset();
        run(999 * DIV_B);
        check_eq("bcd_0999", 32'(num_b), 32'h0999);
        run(DIV_B);
        check_eq("bcd_1000", 32'(num_b), 32'h1000);
        $display("bcd_carry: bcd=%h", num_b);

        // Soft reset from 0x0042.
        do_reset();
        run(16'h42 * DIV_H);
        check_eq("soft_pre", 32'(num_h), 32'h0042);
        pulse_key(0);
        run(2);
        check_eq("soft_not_yet", 32'(num_h), 32'h0042);
        step();
        check_eq("soft_cleared", 32'(num_h), 32'h0);
        check_eq("soft_led", 32'(led_h), 32'h1);
        run(DIV_H - 1);
        check_eq("soft_hold", 32'(num_h), 32'h0);
        step();
        check_eq("soft_first_inc", 32'(num_h), 32'h1);
        $display("soft_reset: hex=%h led=%b", num_h, led_h);

        // Pause, then single steps.
        pulse_key(1);
        run(2);
        frozen = m_val[0];
        run(200);
        check_eq("pause_frozen", 32'(num_h), 32'(frozen));
        check_eq("pause_led", 32'(led_h[0]), 32'h0);
        $display("pause: hex=%h led=%b", num_h, led_h);
        for (int k = 1; k <= 3; k++) begin
            pulse_key(3);
            step();
            check_eq("step_early", 32'(num_h), 32'((frozen + k - 1) & 16'hFFFF));
            step();
            check_eq("step_visible", 32'(num_h), 32'((frozen + k) & 16'hFFFF));
            run(5);
            $display("step %0d: hex=%h", k, num_h);
        end
        pulse_key(1);
        run(5);
        check_eq("resume_led", 32'(led_h[0]), 32'h1);

        // Collision: run-toggle edge lands on the tick edge.
        found = 1'b0;
        for (int k = 0; k < 4 * DIV_H && !found; k++) begin
            if (m_run[0] && m_phase[0] == DIV_H - 3) found = 1'b1;
            else step();
        end
        check_eq("collision_align", 32'(found), 32'h1);
        v = m_val[0];
        pulse_key(1);
        run(2);
        check_eq("collision_inc", 32'(num_h), 32'((v + 1) & 16'hFFFF));
        check_eq("collision_paused", 32'(led_h[0]), 32'h0);
        run(100);
        check_eq("collision_hold", 32'(num_h), 32'((v + 1) & 16'hFFFF));
        $display("collision: hex=%h led=%b", num_h, led_h);

        // Randomized key activity with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                int b;
                b = $urandom_range(1, 3);
                key_sw_p[b] = ~key_sw_p[b];
            end
            key_sw_p[0] = ($urandom_range(0, 299) == 0);
            reset_p     = ($urandom_range(0, 599) == 0);
            step();
        end
        reset_p  = 1'b0;
        key_sw_p = '0;
        run(10);
        $display("random: hex=%h bcd=%h", num_h, num_b);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_counter_gen.md
# display_counter_gen

Parametrised, synthesizable stimulus generator for the lab display path. It produces an N-digit hex or decimal counter on `display_number`, advanced by a programmable prescaler tick. Synchronized push-keys control run/pause, direction and single-step. It replaces fixed simulation-only counting in the board top level and feeds the existing seven-segment/display driver and LEDs directly.

## Interface
- `N_DIGITS`, 4: number of 4-bit digits; `display_number` width is 4*N_DIGITS; legal range 1..8.
- `DECIMAL`, 0: 0 = hex digits (0..F); 1 = BCD digits (0..9).
- `TICK_DIV`, 50_000_000: clock cycles per count tick when `is_simulation`=0; minimum 2.
- `SIM_TICK_DIV`, 16: clock cycles per tick when `is_simulation`=1; minimum 2.
- `is_simulation`, 0: selects the tick divider.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset_p`  in  1  synchronous, active-high reset.
- `key_sw_p`  in  4  raw keys, active-high, asynchronous to `clk`. [0] soft reset; [1] run/pause toggle (rising edge); [2] direction (level: 0 up, 1 down); [3] single step (rising edge, PAUSE only).
- `display_number`  out  4*N_DIGITS  counter value; digit 0 is in [3:0].
- `led_p`  out  4  [0] running; [1] direction; [2] sticky wrap flag; [3] heartbeat, toggles on every count event.

## Operation
- Key synchronizer: two-flop chain z1→z2 per key, plus a z3 stage for edge detection. Rising edge = z2 & ~z3. Direction uses the z2 level.
- Internal reset: `rst_i = reset_p | rst_key_r`, where `rst_key_r <= key z2[0]`. The synchronizer flops are not cleared by `rst_i`; they are cleared only by `reset_p`.
- Reset values:
  - `display_number` = 0, `led_p` = 4'b0001, prescaler = 0, wrap flag = 0, heartbeat = 0.
  - State = RUN.
- States: RUN and PAUSE.
  - RUN → PAUSE on a key[1] edge.
  - PAUSE → RUN on a key[1] edge.
  - There are no other transitions.
- Prescaler:
  - In RUN, counts 0..DIV-1, where DIV = `is_simulation` ? SIM_TICK_DIV : TICK_DIV.
  - `tick` is asserted for one cycle when prescaler == DIV-1; the prescaler then wraps to 0.
  - In PAUSE, the prescaler is held at 0.
  - Prescaler width is $clog2(DIV).
- Count event:
  - In RUN, a count event is `tick`.
  - In PAUSE, a count event is a key[3] edge.
  - The decision uses the current-cycle state.
- Arithmetic:
  - Digit-wise ripple carry (up) or borrow (down); digit maximum is 9 or 15.
  - Up from all-max gives 0. Down from 0 gives all-max.
  - Either wrap sets the sticky wrap flag (`led_p[2]`) until `rst_i`.
- Simultaneous events:
  - A key[1] edge and `tick` in the same RUN cycle: the count is applied, then the state becomes PAUSE.
  - A key[1] edge and a key[3] edge in PAUSE: the state becomes RUN and the step is ignored.
  - A direction change takes effect from the next count event.
- `rst_i` has priority over every event.
- `led_p[0]` = (state == RUN), registered. `led_p[1]` = direction, registered.

## Timing
- All outputs are registered; no combinational path from input to output.
- Raw key change sampled at clock edge n gives:
  - z2 at n+2;
  - edge-driven counter/state update visible after edge n+3;
  - `key_sw_p[0]` clears the outputs after edge n+4.
- `reset_p` high at edge n gives outputs at reset values after edge n.
- Run timing:
  - After reset release, the first increment is visible exactly DIV cycles later.
  - Subsequent increments follow every DIV cycles.
- A pause followed by resume restarts the full DIV period.
- Reset mid-count or mid-pause: immediate return to the reset values and the RUN state.

## Structure
- Package `display_gen_pkg`:
  - `typedef enum logic {ST_RUN, ST_PAUSE} gen_state_t`;
  - key index localparams `KEY_RST`, `KEY_RUN`, `KEY_DIR`, `KEY_STEP`;
  - function `digit_max(DECIMAL)`.
- Sub-module `key_sync_edge`:
  - per-key 3-flop synchronizer with outputs `level` and `rise`;
  - parametrised by key count.
- The top of the block instantiates `key_sync_edge` and contains the prescaler, FSM, digit counter (generate loop over digits) and LED register.

## Test plan
- Hex count: `is_simulation`=1, N_DIGITS=4, reset then run 256 cycles → `display_number` = 16'h0010 and `led_p[3]` = 0.
- Wrap down: after reset, hold key[2]=1 → after 16 cycles `display_number` = 16'hFFFF and `led_p[2]` = 1. The flag stays set after direction returns to up.
- BCD: DECIMAL=1, counted to 0x0999 → next tick gives 0x1000; no digit ever exceeds 9.
- Pause/step:
  - key[1] pulse, then 200 idle cycles → value frozen and `led_p[0]` = 0;
  - three key[3] pulses → value +3, each step visible 3 cycles after its key.
- Soft reset: key[0] pulsed with value 0x0042 → 0x0000 four cycles later; state RUN; next increment DIV cycles after `rst_i` drops.
- Collision: key[1] edge aligned with `tick` → value increments once, then PAUSE; no further change over 100 cycles.
